reg_alu_seq: RTL



---
 rtl/reg_alu_seq.sv | 78 +++++++
 1 files changed

// File: rtl/reg_alu_seq.sv
// reg_alu_seq: multi-cycle READ/EXEC/WB sequencer driving the 8x16 register file + ALU datapath
module reg_alu_seq #(
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [15:0]      instr,
  input  logic [15:0]      imm,
  output logic             sel,
  output logic             wr,
  output logic [2:0]       op,
  output logic [2:0]       rd_addr_a,
  output logic [2:0]       rd_addr_b,
  output logic [2:0]       wr_addr,
  output logic [15:0]      d_in,
  input  logic             alu_cout,
  output logic             carry_flag,
  output logic             done,
  output logic             busy,
  output logic [CNT_W-1:0] retired
);
  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;
  state_t state, nxt;
  logic [15:2] ir;
  logic [15:0] im;
  logic [1:0]  cnt;
  logic        rd_phase;
  logic        unused;
  assign unused = ^instr[1:0];
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ir         <= '0;
      im         <= '0;
      cnt        <= '0;
      carry_flag <= 1'b0;
      retired    <= '0;
    end else begin
      if (state == IDLE && instr_valid) begin
        ir <= instr[15:2];
        im <= imm;
      end
      if (state == READ) cnt <= 2'(ALU_LAT - 1);
      else if (state == EXEC) cnt <= cnt - 1'b1;
      if (state == WB) begin
        retired <= retired + 1'b1;
        if (!ir[14]) carry_flag <= alu_cout;
      end
    end
  // kind[14]=1 marks LDI/NOP, which skip the operand read phases
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = instr_valid ? (instr[14] ? WB : READ) : IDLE;
      READ: nxt = EXEC;
      EXEC: nxt = (cnt == 2'd0) ? WB : EXEC;
      WB:   nxt = IDLE;
    endcase
  end
  always_comb begin
    rd_phase    = state == READ || state == EXEC || (state == WB && !ir[14]);
    instr_ready = state == IDLE;
    busy        = state != IDLE;
    done        = state == WB;
    op          = rd_phase ? ir[13:11] : 3'd0;
    rd_addr_a   = rd_phase ? ir[7:5] : 3'd0;
    rd_addr_b   = rd_phase ? ir[4:2] : 3'd0;
    wr          = state == WB && !ir[15];
    sel         = state == WB && ir[15:14] == 2'b00;
    wr_addr     = wr ? ir[10:8] : 3'd0;
    d_in        = (state == WB && ir[15:14] == 2'b01) ? im : 16'd0;
  end
endmodule
